// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared defaults, state enum and queue entry type for the fetch block
package fetch_pkg;

    localparam int FETCH_ADDR_W = 16;
    localparam int FETCH_DATA_W = 32;
    localparam logic [FETCH_ADDR_W-1:0] FETCH_RESET_PC = 16'h0000;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    // One prefetched instruction tagged with the word address it came from
    typedef struct packed {
        logic [FETCH_ADDR_W-1:0] pc;
        logic [FETCH_DATA_W-1:0] data;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - small synchronous FIFO of tagged instruction words
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  fetch_entry_t     push_entry,
    input  logic             pop,
    input  logic             flush,
    output logic [CNT_W-1:0] count,
    output logic             head_valid,
    output fetch_entry_t     head
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    // Flush discards everything, including a word arriving in the same cycle;
    // the producer's credit check keeps push from ever overflowing.
    assign do_push    = push && !flush;
    assign do_pop     = pop && (count != '0);
    assign head_valid = (count != '0);
    // Head reads as zero while empty so the consumer never sees stale tags
    assign head       = head_valid ? mem[rd_ptr] : '0;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Entry storage; contents are only observable through head when count is non-zero
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - instruction fetch PC, ROM issue, redirect/halt control
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = FETCH_ADDR_W,
    parameter int                DATA_W   = FETCH_DATA_W,
    parameter logic [ADDR_W-1:0] RESET_PC = FETCH_RESET_PC,
    parameter int                DEPTH    = 2
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              halt,
    output logic              inst_valid,
    output logic [DATA_W-1:0] inst_data,
    output logic [ADDR_W-1:0] inst_pc,
    input  logic              inst_ready,
    output logic              halted
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    fetch_state_t      state;
    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] inflight_pc;
    logic              inflight;
    logic [CNT_W-1:0]  q_count;
    logic [CNT_W:0]    q_used;
    logic [CNT_W:0]    q_limit;
    logic              pop;
    logic              issue;
    fetch_entry_t      push_entry;
    fetch_entry_t      head;

    assign rom_addr = fetch_pc;
    assign pop      = inst_valid && inst_ready;

    // Credit check: queued words plus the one in flight must leave room for
    // another, counting the slot freed by a pop in this same cycle.
    assign q_used  = {1'b0, q_count} + (CNT_W + 1)'(inflight);
    assign q_limit = (CNT_W + 1)'(DEPTH) + (CNT_W + 1)'(pop);
    assign issue   = (state == FETCH) && !redirect_valid && (q_used < q_limit);

    assign push_entry.pc   = inflight_pc;
    assign push_entry.data = rom_data;

    // A redirect flushes the queue and also blocks the in-flight word from landing
    fetch_queue #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_queue (
        .clk        (clk),
        .rst        (rst),
        .push       (inflight),
        .push_entry (push_entry),
        .pop        (pop),
        .flush      (redirect_valid),
        .count      (q_count),
        .head_valid (inst_valid),
        .head       (head)
    );

    assign inst_data = head.data;
    assign inst_pc   = head.pc;

    // Fetch PC, in-flight tag and the FETCH/DRAIN/HALTED control state
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= FETCH;
            halted      <= 1'b0;
            fetch_pc    <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else begin
            inflight <= issue;
            if (issue) begin
                inflight_pc <= fetch_pc;
            end
            if (redirect_valid) begin
                fetch_pc <= redirect_pc;
            end else if (issue) begin
                fetch_pc <= fetch_pc + ADDR_W'(1);
            end
            case (state)
                FETCH: begin
                    if (halt) begin
                        state <= DRAIN;
                    end
                end
                // ROM latency is one cycle, so any word in flight on entry
                // lands during this cycle and DRAIN never has to linger.
                DRAIN: begin
                    if (halt) begin
                        state  <= HALTED;
                        halted <= 1'b1;
                    end else begin
                        state <= FETCH;
                    end
                end
                HALTED: begin
                    if (!halt) begin
                        state  <= FETCH;
                        halted <= 1'b0;
                    end
                end
                default: begin
                    state  <= FETCH;
                    halted <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - self-checking bench for fetch_sequencer
`timescale 1ns/1ps
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        halt;
    logic        inst_ready;

    logic [15:0] rom_addr, inst_pc;
    logic [31:0] rom_data, inst_data;
    logic        inst_valid, halted;

    logic [15:0] rom_addr_w, inst_pc_w;
    logic [31:0] rom_data_w, inst_data_w;
    logic        inst_valid_w, halted_w;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    fetch_sequencer #(
        .ADDR_W(16), .DATA_W(32), .RESET_PC(16'h0000), .DEPTH(2)
    ) dut (
        .clk(clk), .rst(rst), .rom_addr(rom_addr), .rom_data(rom_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt),
        .inst_valid(inst_valid), .inst_data(inst_data), .inst_pc(inst_pc),
        .inst_ready(inst_ready), .halted(halted)
    );

    fetch_sequencer #(
        .ADDR_W(16), .DATA_W(32), .RESET_PC(16'hFFFE), .DEPTH(2)
    ) dut_w (
        .clk(clk), .rst(rst), .rom_addr(rom_addr_w), .rom_data(rom_data_w),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt),
        .inst_valid(inst_valid_w), .inst_data(inst_data_w), .inst_pc(inst_pc_w),
        .inst_ready(inst_ready), .halted(halted_w)
    );

    function automatic logic [31:0] rom_word(input logic [15:0] a);
        return 32'(a) + 32'h100;
    endfunction

    // One-cycle-latency ROM model for both instances
    always @(posedge clk) begin
        rom_data   <= rom_word(rom_addr);
        rom_data_w <= rom_word(rom_addr_w);
    end

    typedef struct packed {
        logic        ready;
        logic        redir;
        logic [15:0] rpc;
        logic        exp_valid;
        logic [15:0] exp_pc;
        logic [15:0] exp_addr;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic check_out(input string tag, input logic ev, input logic [15:0] epc,
                             input logic [15:0] ea, input logic eh);
        check({tag, " inst_valid"}, 32'(inst_valid), 32'(ev));
        check({tag, " rom_addr"}, 32'(rom_addr), 32'(ea));
        check({tag, " halted"}, 32'(halted), 32'(eh));
        if (ev) begin
            check({tag, " inst_pc"}, 32'(inst_pc), 32'(epc));
            check({tag, " inst_data"}, inst_data, rom_word(epc));
        end
    endtask

    task automatic add_vec(input logic r, input logic rv, input logic [15:0] rp,
                           input logic ev, input logic [15:0] ep, input logic [15:0] ea);
        vec_t v;
        v.ready = r; v.redir = rv; v.rpc = rp;
        v.exp_valid = ev; v.exp_pc = ep; v.exp_addr = ea;
        tbl.push_back(v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench in the first cycle with rst low
    task automatic do_reset();
        rst = 1'b1; halt = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        logic [15:0] exp_pc;
        logic [15:0] prev_pc;
        logic [31:0] prev_data;
        logic        prev_hold;
        logic [1:0]  hh;
        int          halt_left;
        int          accepted;

        rst = 1'b1; halt = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b0;

        // Stream start, 5-cycle backpressure, release, then redirect to 0x40
        add_vec(1, 0, 0,     0, 0,     16'h0000);
        add_vec(1, 0, 0,     0, 0,     16'h0001);
        add_vec(0, 0, 0,     1, 0,     16'h0002);
        add_vec(0, 0, 0,     1, 0,     16'h0002);
        add_vec(0, 0, 0,     1, 0,     16'h0002);
        add_vec(0, 0, 0,     1, 0,     16'h0002);
        add_vec(0, 0, 0,     1, 0,     16'h0002);
        add_vec(1, 0, 0,     1, 0,     16'h0002);
        add_vec(1, 0, 0,     1, 1,     16'h0003);
        add_vec(1, 0, 0,     1, 2,     16'h0004);
        add_vec(1, 0, 0,     1, 3,     16'h0005);
        add_vec(1, 0, 0,     1, 4,     16'h0006);
        add_vec(0, 1, 16'h40, 1, 5,    16'h0007);
        add_vec(1, 0, 0,     0, 0,     16'h0040);
        add_vec(1, 0, 0,     0, 0,     16'h0041);
        add_vec(1, 0, 0,     1, 16'h40, 16'h0042);
        add_vec(1, 0, 0,     1, 16'h41, 16'h0043);

        do_reset();
        for (int i = 0; i < tbl.size(); i++) begin
            inst_ready     = tbl[i].ready;
            redirect_valid = tbl[i].redir;
            redirect_pc    = tbl[i].rpc;
            check_out($sformatf("vec%0d", i), tbl[i].exp_valid, tbl[i].exp_pc,
                      tbl[i].exp_addr, 1'b0);
            tick();
        end
        redirect_valid = 1'b0;

        // Address wrap from RESET_PC 0xFFFE
        do_reset();
        inst_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            if (c == 0) check("wrap rom_addr c0", 32'(rom_addr_w), 32'h0000FFFE);
            if (c >= 2) begin
                logic [15:0] wp;
                wp = 16'hFFFE + 16'(c - 2);
                check($sformatf("wrap c%0d inst_valid", c), 32'(inst_valid_w), 32'd1);
                check($sformatf("wrap c%0d inst_pc", c), 32'(inst_pc_w), 32'(wp));
                check($sformatf("wrap c%0d inst_data", c), inst_data_w, rom_word(wp));
            end
            tick();
        end

        // Halt for six cycles mid-stream
        do_reset();
        inst_ready = 1'b1;
        repeat (6) tick();
        halt = 1'b1;
        check_out("halt c6", 1, 16'd4, 16'd6, 0); tick();
        check_out("halt c7", 1, 16'd5, 16'd7, 0); tick();
        check_out("halt c8", 1, 16'd6, 16'd7, 1); tick();
        check_out("halt c9", 0, 16'd0, 16'd7, 1); tick(); tick();
        check_out("halt c11", 0, 16'd0, 16'd7, 1); tick();
        halt = 1'b0;
        check_out("halt c12", 0, 16'd0, 16'd7, 1); tick();
        check_out("halt c13", 0, 16'd0, 16'd7, 0); tick(); tick();
        check_out("halt c15", 1, 16'd7, 16'd9, 0); tick();

        // Redirect and halt together
        halt = 1'b1; redirect_valid = 1'b1; redirect_pc = 16'h0080;
        tick();
        redirect_valid = 1'b0;
        check_out("hr x1", 0, 16'd0, 16'h0080, 0); tick();
        check_out("hr x2", 0, 16'd0, 16'h0080, 1);
        halt = 1'b0;
        tick();
        for (int k = 0; k < 8 && !inst_valid; k++) tick();
        check("hr resume inst_valid", 32'(inst_valid), 32'd1);
        check("hr resume inst_pc", 32'(inst_pc), 32'h0080);
        check("hr resume inst_data", inst_data, rom_word(16'h0080));

        // Reset mid-stream with a full queue
        inst_ready = 1'b0;
        repeat (3) tick();
        check("rst pre inst_valid", 32'(inst_valid), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_out("rst c0", 0, 16'd0, 16'd0, 0);
        check("rst c0 inst_pc", 32'(inst_pc), 32'd0);
        check("rst c0 inst_data", inst_data, 32'd0);
        inst_ready = 1'b1;
        tick(); tick();
        check_out("rst c2", 1, 16'd0, 16'd2, 0);

        // Randomized traffic against an in-order stream model
        do_reset();
        exp_pc = 16'h0000; prev_hold = 1'b0; prev_pc = '0; prev_data = '0;
        hh = 2'b00; halt_left = 0; accepted = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            inst_ready = ($urandom_range(0, 9) < 7);
            if (halt_left > 0) begin
                halt = 1'b1;
                halt_left--;
            end else begin
                halt = 1'b0;
                if ($urandom_range(0, 49) == 0) halt_left = $urandom_range(1, 8);
            end
            redirect_valid = ($urandom_range(0, 39) == 0);
            redirect_pc    = 16'($urandom);

            if (prev_hold) begin
                check("rand hold inst_valid", 32'(inst_valid), 32'd1);
                check("rand hold inst_pc", 32'(inst_pc), 32'(prev_pc));
                check("rand hold inst_data", inst_data, prev_data);
            end
            if (hh[0] && hh[1] && halt) check("rand halted high", 32'(halted), 32'd1);
            if (!hh[0]) check("rand halted low", 32'(halted), 32'd0);
            if (inst_valid && inst_ready) begin
                check("rand inst_pc", 32'(inst_pc), 32'(exp_pc));
                check("rand inst_data", inst_data, rom_word(exp_pc));
                exp_pc = exp_pc + 16'd1;
                accepted++;
            end
            if (redirect_valid) exp_pc = redirect_pc;

            prev_hold = inst_valid && !inst_ready && !redirect_valid;
            prev_pc   = inst_pc;
            prev_data = inst_data;
            hh        = {hh[0], halt};
            tick();
        end
        check("rand accepted>=800", 32'(accepted >= 800), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction fetch controller that sits between the core's decode stage and the 2^16 × 32 instruction ROM. It owns the fetch program counter and issues one word address per cycle to the ROM. It tags each returned word with its address and buffers it in a small prefetch queue drained by a valid/ready handshake. It also handles branch/jump redirects (flushing stale words) and a halt request that stops new fetches.

## Interface
Parameters:
- ADDR_W, 16, word address width (ROM index width)
- DATA_W, 32, instruction word width
- RESET_PC, 16'h0000, first fetch address after reset
- DEPTH, 2, prefetch queue entries (≥2)

Ports:
- clk  in  1  single system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- rom_addr  out  ADDR_W  word address to ROM; equals fetch_pc combinationally
- rom_data  in  DATA_W  ROM read data, valid the cycle after the address was issued
- redirect_valid  in  1  load new PC and flush
- redirect_pc  in  ADDR_W  redirect target
- halt  in  1  level; while high no new fetches issue
- inst_valid  out  1  queue head valid
- inst_data  out  DATA_W  queue head instruction
- inst_pc  out  ADDR_W  address of inst_data
- inst_ready  in  1  consumer accepts head
- halted  out  1  in HALTED state

## Operation
- State machine (fetch_pkg enum): FETCH, DRAIN, HALTED.
  - FETCH: halt=1 → DRAIN.
  - DRAIN: no issue. Goes to HALTED once no fetch is in flight, or immediately if the in-flight word has already been captured. halt=0 → FETCH.
  - HALTED: halt=0 → FETCH. The queue keeps draining to the consumer in all states.
- Issue condition: state==FETCH, no redirect this cycle, and count + inflight − pop < DEPTH.
  - pop = inst_valid & inst_ready.
  - On issue: inflight ← 1, inflight_pc ← fetch_pc, fetch_pc ← fetch_pc + 1.
- Address wrap: fetch_pc 0xFFFF + 1 → 0x0000; no flag, no stall.
- Capture: if inflight is 1 and was not squashed, rom_data is pushed at the end of the cycle with tag inflight_pc. Capture never overflows; the credit check guarantees space.
- Redirect (cycle R):
  - Empties the queue, squashes any in-flight word, and loads fetch_pc ← redirect_pc.
  - No issue in cycle R. The state is unaffected.
  - A pop in cycle R is still a completed handshake.
  - Redirect while DRAIN/HALTED updates the PC; fetching resumes from the new PC when halt drops.
- Redirect and halt in the same cycle: redirect is applied and the state goes to DRAIN; nothing is issued.
- Queue is FIFO order. inst_data and inst_pc stay stable while inst_valid=1 and inst_ready=0.

## Timing
- Reset (rst=1 at an edge):
  - fetch_pc=RESET_PC, so rom_addr=RESET_PC.
  - Queue empty, inflight=0, state FETCH.
  - inst_valid=0, inst_data=0, inst_pc=0, halted=0.
  - Reset mid-operation discards queue and in-flight word identically.
- First issue is in the first cycle with rst=0.
- Fetch latency: issue in cycle N → rom_data in N+1 → inst_valid with that word in N+2.
- Throughput: with inst_ready held 1, one instruction per cycle sustained from N+2 onward at DEPTH=2.
- Redirect latency: redirect in R → rom_addr=target in R+1 → inst_valid, inst_pc=target in R+3. inst_valid=0 in R+1 and R+2.
- Backpressure: with inst_ready=0, issue stops once count+inflight=DEPTH. With inst_ready back to 1, the next issue happens in the same cycle as the pop.
- halted asserts the cycle after the in-flight word lands, i.e. two cycles after halt rises if a fetch was in flight.

## Structure
- Package fetch_pkg holds ADDR_W, DATA_W, RESET_PC defaults, the state enum {FETCH, DRAIN, HALTED}, and the queue entry struct {pc, data}.
- Sub-module fetch_queue: synchronous FIFO of DEPTH entries with push, pop, flush, count, head outputs. Flush has priority over push; pop and flush in the same cycle is legal.
- fetch_sequencer holds the PC register, inflight flag/tag, credit logic and FSM.

## Test plan
- Reset then inst_ready=1, ROM[i]=i+0x100:
  - rom_addr=0,1,2… in consecutive cycles.
  - inst_valid first at cycle 2 with inst_pc=0, inst_data=0x100.
  - Then one per cycle, in order.
- inst_ready=0 for 5 cycles after the first valid:
  - At most DEPTH words are queued plus none in flight.
  - inst_data and inst_pc are held.
  - After release, the sequence continues with no gap or duplicate.
- redirect_valid with redirect_pc=0x0040 while the queue is full and a fetch is in flight:
  - inst_valid=0 for 2 cycles.
  - Then inst_pc=0x0040, 0x0041…
  - No pre-redirect word appears.
- RESET_PC=16'hFFFE, continuous ready: inst_pc sequence is FFFE, FFFF, 0000, 0001.
- halt=1 for 6 cycles mid-stream:
  - Issue stops, and halted rises once the in-flight word is captured.
  - Queued words still drain.
  - After halt drops, fetching resumes at the next sequential PC.
  - Redirect and halt in the same cycle: resumes at redirect_pc.
- rst asserted for 1 cycle mid-stream with a full queue:
  - Next cycle inst_valid=0 and rom_addr=RESET_PC.
  - First post-reset word has inst_pc=RESET_PC.
